snake_body_scheduler: RTL

Steps the snake's body on a fixed move tick during play and tracks every segment position. After each step it checks for wall and self collisions, then reports collisions (`bump`) and cherry hits (`snakeEatCherry`) to the game controller. It takes the target length `size` from the game controller. It also serves a registered pixel-cell hit query to the VGA renderer. The block sits between the game controller, the direction-input decoder, the cherry generator and the display path.

---
 rtl/snake_body_scheduler_if.sv | 29 ++
 rtl/snake_body_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/snake_body_scheduler_if.sv
// Signal bundle between the snake body scheduler and the game controller, direction decoder,
// cherry generator and VGA renderer.
interface snake_body_scheduler_if;
  logic       gamePrepare;
  logic       gameStart;
  logic [4:0] size;
  logic [1:0] dir_in;
  logic [4:0] cherry_x;
  logic [4:0] cherry_y;
  logic [4:0] qry_x;
  logic [4:0] qry_y;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic       snakeEatCherry;
  logic       bump;
  logic       move_tick;
  logic       qry_hit;
  logic       qry_head;

  modport master (
    output gamePrepare, gameStart, size, dir_in, cherry_x, cherry_y, qry_x, qry_y,
    input  head_x, head_y, snakeEatCherry, bump, move_tick, qry_hit, qry_head
  );

  modport slave (
    input  gamePrepare, gameStart, size, dir_in, cherry_x, cherry_y, qry_x, qry_y,
    output head_x, head_y, snakeEatCherry, bump, move_tick, qry_hit, qry_head
  );
endinterface

// File: rtl/snake_body_scheduler.sv
// Moves the snake body once per move tick, checks wall and self collisions over a fixed
// scan window, reports cherry hits, and answers registered per-cell queries for the renderer.
module snake_body_scheduler #(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int MAX_LEN     = 31,
  parameter int TICK_CYCLES = 5_000_000
) (
  input logic                   clk,
  input logic                   reset,
  snake_body_scheduler_if.slave bus
);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int KW = $clog2(MAX_LEN);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [4:0]    START_X   = 5'(GRID_W / 2);
  localparam logic [4:0]    START_Y   = 5'(GRID_H / 2);
  localparam logic [4:0]    X_MAX     = 5'(GRID_W - 1);
  localparam logic [4:0]    Y_MAX     = 5'(GRID_H - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [KW-1:0] CHK_LAST  = KW'(MAX_LEN - 1);

  typedef enum logic [2:0] {IDLE, WAIT, SHIFT, CHECK, RESULT} state_t;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    dir_q;
  logic [LW-1:0] cur_len_q;
  logic [KW-1:0] chk_q;
  logic          coll_q;
  logic          bump_q;
  logic          eat_q;
  logic          move_tick_q;
  logic          qry_hit_q;
  logic          qry_head_q;
  logic [4:0]    seg_x_q [MAX_LEN];
  logic [4:0]    seg_y_q [MAX_LEN];

  logic [1:0] dir_d;
  logic [4:0] head_x_d;
  logic [4:0] head_y_d;
  logic       wall_d;
  logic       grow_d;
  logic       coll_d;
  logic       cherry_hit_d;
  logic       qry_hit_d;
  logic       qry_head_d;

  // A request for the exact opposite direction would fold the head back into the neck.
  assign dir_d = (bus.dir_in == (dir_q ^ 2'b10)) ? dir_q : bus.dir_in;

  always_comb begin
    head_x_d = seg_x_q[0];
    head_y_d = seg_y_q[0];
    wall_d   = 1'b0;
    case (dir_d)
      DIR_UP:    if (seg_y_q[0] == 5'd0)  wall_d = 1'b1; else head_y_d = seg_y_q[0] - 5'd1;
      DIR_RIGHT: if (seg_x_q[0] == X_MAX) wall_d = 1'b1; else head_x_d = seg_x_q[0] + 5'd1;
      DIR_DOWN:  if (seg_y_q[0] == Y_MAX) wall_d = 1'b1; else head_y_d = seg_y_q[0] + 5'd1;
      DIR_LEFT:  if (seg_x_q[0] == 5'd0)  wall_d = 1'b1; else head_x_d = seg_x_q[0] - 5'd1;
      default:   wall_d = 1'b0;
    endcase
  end

  assign grow_d = (int'(cur_len_q) < int'(bus.size)) && (int'(cur_len_q) < MAX_LEN);

  assign coll_d = coll_q || ((int'(chk_q) < int'(cur_len_q)) &&
                             (seg_x_q[chk_q] == seg_x_q[0]) && (seg_y_q[chk_q] == seg_y_q[0]));

  assign cherry_hit_d = (seg_x_q[0] == bus.cherry_x) && (seg_y_q[0] == bus.cherry_y);

  always_comb begin
    qry_hit_d  = 1'b0;
    qry_head_d = (seg_x_q[0] == bus.qry_x) && (seg_y_q[0] == bus.qry_y);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(cur_len_q)) && (seg_x_q[i] == bus.qry_x) && (seg_y_q[i] == bus.qry_y)) begin
        qry_hit_d = 1'b1;
      end
    end
  end

  // The collision verdict is folded in on the last scan cycle so bump/eat are visible in RESULT.
  always_ff @(posedge clk) begin
    if (!reset || bus.gamePrepare) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      dir_q       <= DIR_RIGHT;
      cur_len_q   <= LW'(1);
      chk_q       <= '0;
      coll_q      <= 1'b0;
      bump_q      <= 1'b0;
      eat_q       <= 1'b0;
      move_tick_q <= 1'b0;
      qry_hit_q   <= 1'b0;
      qry_head_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
      seg_x_q[0] <= START_X;
      seg_y_q[0] <= START_Y;
    end else begin
      move_tick_q <= 1'b0;
      eat_q       <= 1'b0;
      qry_hit_q   <= qry_hit_d;
      qry_head_q  <= qry_head_d;
      case (state_q)
        IDLE: begin
          if (bus.gameStart && !bump_q) state_q <= WAIT;
        end
        WAIT: begin
          if (!bus.gameStart) begin
            state_q <= IDLE;
          end else if (tick_q == TICK_LAST) begin
            tick_q      <= '0;
            state_q     <= SHIFT;
            move_tick_q <= 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        SHIFT: begin
          dir_q <= dir_d;
          if (wall_d) begin
            bump_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_q[i] <= seg_x_q[i-1];
              seg_y_q[i] <= seg_y_q[i-1];
            end
            seg_x_q[0] <= head_x_d;
            seg_y_q[0] <= head_y_d;
            if (grow_d) cur_len_q <= cur_len_q + 1'b1;
            chk_q   <= KW'(1);
            coll_q  <= 1'b0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          coll_q <= coll_d;
          if (chk_q == CHK_LAST) begin
            state_q <= RESULT;
            if (coll_d) bump_q <= 1'b1;
            else if (cherry_hit_d) eat_q <= 1'b1;
          end else begin
            chk_q <= chk_q + 1'b1;
          end
        end
        RESULT: begin
          state_q <= bump_q ? IDLE : WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.head_x         = seg_x_q[0];
  assign bus.head_y         = seg_y_q[0];
  assign bus.snakeEatCherry = eat_q;
  assign bus.bump           = bump_q;
  assign bus.move_tick      = move_tick_q;
  assign bus.qry_hit        = qry_hit_q;
  assign bus.qry_head       = qry_head_q;
endmodule
